// File: rtl/spectrum_pkg.sv
// Shared constants for the spectrum histogram path: FSM one-hot encoding,
// stream sync bytes and channel count. Also used by the accumulator.
package spectrum_pkg;

   localparam int CHAN_BITS_DEF = 10;
   localparam int NUM_CHANNELS  = 1 << CHAN_BITS_DEF;

   localparam logic [7:0] SYNC0_BYTE = 8'hA5;
   localparam logic [7:0] SYNC1_BYTE = 8'h5A;

   localparam logic [7:0] ST_IDLE   = 8'b0000_0001;
   localparam logic [7:0] ST_SYNC0  = 8'b0000_0010;
   localparam logic [7:0] ST_SYNC1  = 8'b0000_0100;
   localparam logic [7:0] ST_ADDR   = 8'b0000_1000;
   localparam logic [7:0] ST_WAIT   = 8'b0001_0000;
   localparam logic [7:0] ST_SEND   = 8'b0010_0000;
   localparam logic [7:0] ST_CSUM   = 8'b0100_0000;
   localparam logic [7:0] ST_FINISH = 8'b1000_0000;

   // Serializer load request: nbytes is the number of bytes to send minus one.
   typedef struct packed {
      logic        load;
      logic [31:0] data;
      logic [1:0]  nbytes;
   } ser_load_t;

endpackage

// File: rtl/spectrum_byte_ser.sv
// 32-bit load/shift register presenting bytes MSB first on a valid/ready
// handshake. A load always wins over a shift so word boundaries have no bubble.
module spectrum_byte_ser
   import spectrum_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  ser_load_t  load_i,
   input  logic       tx_ready_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   output logic       fire_o,
   output logic       last_o
);

   logic [31:0] sreg_q, sreg_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        vld_q, vld_d;

   assign fire_o     = vld_q & tx_ready_i;
   assign last_o     = fire_o & (cnt_q == 2'd0);
   assign tx_data_o  = sreg_q[31:24];
   assign tx_valid_o = vld_q;

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      if (load_i.load) begin
         sreg_d = load_i.data;
         cnt_d  = load_i.nbytes;
         vld_d  = 1'b1;
      end else if (fire_o) begin
         if (cnt_q == 2'd0) begin
            vld_d = 1'b0;
         end else begin
            sreg_d = {sreg_q[23:0], 8'h00};
            cnt_d  = cnt_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sreg_q <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/spectrum_readout.sv
// Dumps the histogram RAM as a byte stream: A5 5A, then each channel count
// MSB first. SPECTRUM_CHECKSUM_EN appends a mod-256 sum of the data bytes.
module spectrum_readout
   import spectrum_pkg::*;
#(
   parameter int CHANNEL_BITS = CHAN_BITS_DEF,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                    CLOCK_65,
   input  logic                    rst_n,
   input  logic                    cmd_dump,
   output logic [CHANNEL_BITS-1:0] channel_address_read,
   input  logic [COUNT_WIDTH-1:0]  channel_count_read,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic                    done
);

   logic [7:0]              state_q, state_d;
   logic [CHANNEL_BITS-1:0] idx_q, idx_d;
   logic [CHANNEL_BITS-1:0] addr_q, addr_d;
   ser_load_t               ld;
   logic                    fire, last;
`ifdef SPECTRUM_CHECKSUM_EN
   logic [7:0]              csum_q, csum_d;
`endif

   assign channel_address_read = addr_q;
   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_FINISH);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      ld      = '0;
`ifdef SPECTRUM_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         ST_IDLE: if (cmd_dump) begin
            state_d = ST_SYNC0;
            idx_d   = '0;
            ld.load = 1'b1;
            ld.data = {SYNC0_BYTE, 24'h0};
`ifdef SPECTRUM_CHECKSUM_EN
            csum_d  = '0;
`endif
         end
         ST_SYNC0: if (fire) begin
            state_d = ST_SYNC1;
            ld.load = 1'b1;
            ld.data = {SYNC1_BYTE, 24'h0};
         end
         ST_SYNC1: if (fire) begin
            state_d = ST_ADDR;
            addr_d  = idx_q;
         end
         ST_ADDR: state_d = ST_WAIT;
         // RAM data for the ADDR-cycle address is on the bus now.
         ST_WAIT: begin
            state_d   = ST_SEND;
            ld.load   = 1'b1;
            ld.data   = channel_count_read;
            ld.nbytes = 2'd3;
         end
         ST_SEND: begin
`ifdef SPECTRUM_CHECKSUM_EN
            if (fire) csum_d = csum_q + tx_data;
`endif
            if (last) begin
               if (idx_q != '1) begin
                  idx_d   = idx_q + 1'b1;
                  addr_d  = idx_q + 1'b1;
                  state_d = ST_ADDR;
               end else begin
`ifdef SPECTRUM_CHECKSUM_EN
                  state_d = ST_CSUM;
                  ld.load = 1'b1;
                  ld.data = {csum_q + tx_data, 24'h0};
`else
                  state_d = ST_FINISH;
`endif
               end
            end
         end
`ifdef SPECTRUM_CHECKSUM_EN
         ST_CSUM: if (fire) state_d = ST_FINISH;
`endif
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_65 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
`ifdef SPECTRUM_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
`ifdef SPECTRUM_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   spectrum_byte_ser u_ser (
      .clk_i      (CLOCK_65),
      .rst_ni     (rst_n),
      .load_i     (ld),
      .tx_ready_i (tx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .fire_o     (fire),
      .last_o     (last)
   );

endmodule

// File: tb/tb_spectrum_readout.sv
// Directed/random bench for spectrum_readout: the expected stream is rebuilt
// from the RAM contents; bytes are captured on every valid/ready handshake.
module tb_spectrum_readout;

   localparam int CB  = 10;
   localparam int NCH = 1 << CB;
`ifdef SPECTRUM_CHECKSUM_EN
   localparam int CS  = 1;
`else
   localparam int CS  = 0;
`endif

   logic          CLOCK_65 = 1'b0;
   logic          rst_n    = 1'b0;
   logic          cmd_dump = 1'b0;
   logic          tx_ready = 1'b0;
   logic [CB-1:0] channel_address_read;
   logic [31:0]   channel_count_read;
   logic [7:0]    tx_data;
   logic          tx_valid, busy, done;

   logic [31:0] mem [NCH];
   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];
   int          n_chk = 0, n_pass = 0;
   int          done_cnt = 0, busy_cnt = 0, stab_err = 0;
   bit          rnd_ready = 1'b0;
   logic        hold = 1'b0;
   logic [7:0]  hold_data = 8'h00;

   spectrum_readout #(.CHANNEL_BITS(CB), .COUNT_WIDTH(32)) dut (
      .CLOCK_65             (CLOCK_65),
      .rst_n                (rst_n),
      .cmd_dump             (cmd_dump),
      .channel_address_read (channel_address_read),
      .channel_count_read   (channel_count_read),
      .tx_data              (tx_data),
      .tx_valid             (tx_valid),
      .tx_ready             (tx_ready),
      .busy                 (busy),
      .done                 (done)
   );

   always #5 CLOCK_65 = ~CLOCK_65;

   // Synchronous-read histogram RAM.
   always @(posedge CLOCK_65) channel_count_read <= mem[channel_address_read];

   // Monitor at the falling edge: handshakes, done pulses, busy cycles and
   // byte stability while the sink stalls.
   always @(negedge CLOCK_65) begin
      if (!rst_n) begin
         hold <= 1'b0;
      end else begin
         if (hold && !(tx_valid === 1'b1 && tx_data === hold_data)) stab_err <= stab_err + 1;
         hold      <= tx_valid && !tx_ready;
         hold_data <= tx_data;
         if (tx_valid && tx_ready) got.push_back(tx_data);
         if (done) done_cnt <= done_cnt + 1;
         if (busy) busy_cnt <= busy_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge CLOCK_65);
      #1;
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
   endtask

   function automatic void build_exp();
      logic [7:0] s;
      logic [7:0] b;
      s = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      for (int ch = 0; ch < NCH; ch++)
         for (int k = 3; k >= 0; k--) begin
            b = mem[ch][8*k +: 8];
            exp_q.push_back(b);
            s = s + b;
         end
      if (CS != 0) exp_q.push_back(s);
   endfunction

   task automatic start();
      cmd_dump = 1'b1;
      tick();
      cmd_dump = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0);
      for (int i = 0; i < 40000; i++) begin
         if (done_cnt > d0 && busy === 1'b0) break;
         tick();
      end
      check({tag, " finished"}, 32'(done_cnt > d0 && busy === 1'b0), 32'd1);
   endtask

   task automatic wait_addr(input string tag, input int ch);
      for (int i = 0; i < 20000; i++) begin
         if (busy === 1'b1 && int'(channel_address_read) == ch) break;
         tick();
      end
      check({tag, " reached channel"}, 32'(channel_address_read), 32'(ch));
   endtask

   task automatic compare_stream(input string tag, input int base, input int d0, input int s0);
      int p;
      build_exp();
      check({tag, " byte count"}, 32'(got.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i >= got.size()) break;
         p = n_pass;
         check($sformatf("%s byte %0d", tag, i), 32'(got[base + i]), 32'(exp_q[i]));
         if (n_pass == p) break;
      end
      check({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
      check({tag, " stable while stalled"}, 32'(stab_err - s0), 32'd0);
   endtask

   task automatic run_full(input string tag, input int repulse_ch, input bit chk_cycles);
      int base, d0, b0, s0;
      base = got.size();
      d0 = done_cnt;
      b0 = busy_cnt;
      s0 = stab_err;
      start();
      if (repulse_ch >= 0) begin
         wait_addr(tag, repulse_ch);
         cmd_dump = 1'b1;
         tick();
         cmd_dump = 1'b0;
      end
      wait_done(tag, d0);
      if (chk_cycles) check({tag, " busy cycles"}, 32'(busy_cnt - b0), 32'(2 + 6*NCH + 1 + CS));
      compare_stream(tag, base, d0, s0);
   endtask

   initial begin
      int base;
      for (int i = 0; i < NCH; i++) mem[i] = 32'(i);

      #12;
      check("reset tx_valid", 32'(tx_valid), 32'd0);
      check("reset tx_data", 32'(tx_data), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset address", 32'(channel_address_read), 32'd0);
      tick();
      rst_n = 1'b1;
      tx_ready = 1'b1;
      repeat (3) tick();

      // Ramp contents, sink always ready: also the minimum-latency case.
      run_full("ramp", -1, 1'b1);

      // Random contents with a 50% stalling sink.
      for (int i = 0; i < NCH; i++) mem[i] = $urandom;
      rnd_ready = 1'b1;
      run_full("random", -1, 1'b0);
      rnd_ready = 1'b0;
      tx_ready = 1'b1;
      repeat (3) tick();

      // A second cmd_dump mid-dump must not restart or queue a dump.
      for (int i = 0; i < NCH; i++) mem[i] = 32'(i);
      run_full("repulse", 100, 1'b1);
      repeat (5) tick();
      check("repulse no queued dump", 32'(busy), 32'd0);

      // Reset mid-dump aborts at once; the next dump starts from the sync bytes.
      start();
      wait_addr("abort", 500);
      rst_n = 1'b0;
      #1;
      check("abort tx_valid", 32'(tx_valid), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort tx_data", 32'(tx_data), 32'd0);
      check("abort address", 32'(channel_address_read), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      base = got.size();
      repeat (5) tick();
      check("abort no bytes after release", 32'(got.size() - base), 32'd0);
      run_full("restart", -1, 1'b1);

`ifdef SPECTRUM_CHECKSUM_EN
      for (int i = 0; i < NCH; i++) mem[i] = 32'h0101_0101;
      run_full("csum ones", -1, 1'b0);
      check("csum ones final", 32'(got[got.size()-1]), 32'h00);
      for (int i = 0; i < NCH; i++) mem[i] = 32'h0000_0003;
      run_full("csum threes", -1, 1'b0);
      check("csum threes final", 32'(got[got.size()-1]), 32'h00);
      for (int i = 0; i < NCH; i++) mem[i] = 32'h0;
      mem[0] = 32'h0000_00FF;
      run_full("csum single", -1, 1'b0);
      check("csum single final", 32'(got[got.size()-1]), 32'hFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
